wb_seq_ctrl: RTL and testbench
==============================

WB_SEQ_CTRL -- requirements
Module: wb_seq_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, meaning the maximum number of WAIT_MEM cycles before a load is aborted (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port instr_valid_i, input, 1, retiring instruction presented for writeback.
REQ-005 SHALL have port ready_o, output, 1, controller accepts an instruction this cycle.
REQ-006 SHALL have port wb_en_i, input, 1, instruction writes rd.
REQ-007 SHALL have port wb_src_i, input, 2, source: 00 ALU, 01 load, 10 PC-link, 11 LUI immediate.
REQ-008 SHALL have port rd_addr_i, input, 5, destination register.
REQ-009 SHALL have port mem_rsp_valid_i, input, 1, data-memory load response valid.
REQ-010 SHALL have port mem_rsp_data_i, input, 32, load response data.
REQ-011 SHALL have port mem_rsp_ready_o, output, 1, controller accepts a load response.
REQ-012 SHALL have port rd_select_o, output, 2, register-file mux select (same encoding as wb_src_i).
REQ-013 SHALL have port load_o, output, 1, load-path select to the register-file mux.
REQ-014 SHALL have port load_data_o, output, 32, captured load data to the mux load input.
REQ-015 SHALL have port reg_we_o, output, 1, register-file write enable.
REQ-016 SHALL have port reg_waddr_o, output, 5, register-file write address.
REQ-017 SHALL have port retire_o, output, 1, one-cycle pulse when an instruction completes writeback.
REQ-018 SHALL have port err_o, output, 1, one-cycle pulse on load timeout.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT_MEM, WRITE, ERR.
REQ-020 SHALL drive ready_o=1 only in IDLE; an instruction is accepted when instr_valid_i && ready_o.
REQ-021 SHALL register wb_en_i, wb_src_i, and rd_addr_i on acceptance and hold them until return to IDLE; input changes after acceptance have no effect.
REQ-022 On acceptance with wb_src_i!=01, SHALL go IDLE->WRITE (accept cycle N, WRITE at N+1, IDLE at N+2).
REQ-023 On acceptance with wb_src_i==01, SHALL go IDLE->WAIT_MEM and clear the timeout counter to 0.
REQ-024 SHALL drive mem_rsp_ready_o=1 only in WAIT_MEM; responses in other states are ignored and not captured.
REQ-025 In WAIT_MEM, on mem_rsp_valid_i, SHALL capture mem_rsp_data_i into load_data_o and go to WRITE next cycle.
REQ-026 In WAIT_MEM without a response, SHALL increment the 8-bit counter; when the counter equals TIMEOUT-1 and no response arrives, SHALL go to ERR. A response in that same cycle wins and goes to WRITE.
REQ-027 SHALL be in ERR for exactly one cycle with err_o=1, reg_we_o=0, retire_o=0, then go to IDLE.
REQ-028 SHALL be in WRITE for exactly one cycle: retire_o=1; reg_we_o = latched wb_en && latched rd!=0; then go to IDLE.
REQ-029 SHALL drive reg_waddr_o=latched rd, rd_select_o=latched wb_src, and load_o=(latched wb_src==01) continuously from acceptance until IDLE is re-entered.
REQ-030 SHALL hold load_data_o between captures; it changes only on a response accepted in WAIT_MEM.
REQ-031 SHALL still perform full load sequencing (wait, capture, timeout) for a load with wb_en=0 or rd=0, suppressing only reg_we_o.
REQ-032 Minimum occupancy SHALL be 2 cycles per non-load instruction and 3 cycles per load.

Reset
REQ-033 SHALL, while rst=1, force state IDLE, counter 0, latched fields 0, load_data_o=0, and reg_we_o=retire_o=err_o=mem_rsp_ready_o=load_o=0, rd_select_o=00, reg_waddr_o=0.
REQ-034 rst SHALL override all inputs in the same cycle, including mid-WAIT_MEM and in WRITE; reg_we_o SHALL be 0 in the cycle after rst is sampled high.
REQ-035 ready_o SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-036 ALU op: accept wb_src=00, rd=5, wb_en=1 at N -> N+1: reg_we=1, reg_waddr=5, rd_select=00, retire=1; N+2: ready=1.
REQ-037 Load: accept wb_src=01, rd=7; response 0xDEADBEEF 3 cycles later -> next cycle: reg_we=1, load=1, load_data_o=0xDEADBEEF, retire=1.
REQ-038 Timeout: TIMEOUT=4 load, no response -> err_o pulses after the 4th WAIT_MEM cycle, reg_we stays 0, and ready=1 the following cycle.
REQ-039 Timeout boundary: response arrives in the 4th WAIT_MEM cycle (TIMEOUT=4) -> WRITE occurs and err_o stays 0.
REQ-040 x0 write: accept wb_src=11, rd=0, wb_en=1 -> retire=1 and reg_we=0; stray mem_rsp_valid in IDLE leaves load_data_o unchanged.
REQ-041 Reset mid-load: assert rst in WAIT_MEM -> all outputs return to reset values; a later response is ignored and ready=1 after rst deasserts.

Source files
------------

// File: rtl/wb_seq_ctrl.sv
// ---------------------------------------------------------------------------
// wb_seq_ctrl
// Writeback sequencing controller. It accepts one retiring instruction at a
// time, waits for the data-memory response when the instruction is a load,
// and then drives the register-file write for exactly one cycle. A load that
// gets no response within TIMEOUT wait cycles is aborted with an error pulse.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   instr_valid_i       retiring instruction presented
//   ready_o             controller idle, accepts an instruction this cycle
//   wb_en_i             instruction writes rd
//   wb_src_i            writeback source: 00 ALU, 01 load, 10 PC-link, 11 LUI
//   rd_addr_i           destination register
//   mem_rsp_valid_i     load response valid
//   mem_rsp_data_i      load response data
//   mem_rsp_ready_o     controller accepts a load response
//   rd_select_o         register-file mux select (wb_src encoding)
//   load_o              load-path select to the register-file mux
//   load_data_o         captured load data
//   reg_we_o            register-file write enable
//   reg_waddr_o         register-file write address
//   retire_o            one-cycle pulse when writeback completes
//   err_o               one-cycle pulse on load timeout
// ---------------------------------------------------------------------------
module wb_seq_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid_i,
  output logic        ready_o,
  input  logic        wb_en_i,
  input  logic [1:0]  wb_src_i,
  input  logic [4:0]  rd_addr_i,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_data_i,
  output logic        mem_rsp_ready_o,
  output logic [1:0]  rd_select_o,
  output logic        load_o,
  output logic [31:0] load_data_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o,
  output logic        retire_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    WRITE,
    ERR
  } state_e;

  localparam logic [1:0] SRC_LOAD = 2'b01;
  // Last wait cycle index; reaching it without a response aborts the load.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  waitCnt_q, waitCnt_d;
  logic        wbEn_q;
  logic [1:0]  wbSrc_q;
  logic [4:0]  rd_q;
  logic [31:0] loadData_q;

  logic accept;
  logic rspAccept;

  assign accept    = instr_valid_i && (state_q == IDLE);
  assign rspAccept = mem_rsp_valid_i && (state_q == WAIT_MEM);

  // State register and wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      waitCnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // Instruction fields are captured only on acceptance, so later input
  // changes are invisible; load data is captured only on an accepted response.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbEn_q     <= 1'b0;
      wbSrc_q    <= 2'b00;
      rd_q       <= 5'd0;
      loadData_q <= 32'd0;
    end else begin
      if (accept) begin
        wbEn_q  <= wb_en_i;
        wbSrc_q <= wb_src_i;
        rd_q    <= rd_addr_i;
      end
      if (rspAccept) begin
        loadData_q <= mem_rsp_data_i;
      end
    end
  end

  // Next-state logic. A response in the final wait cycle still wins over
  // the timeout.
  always_comb begin
    state_d   = state_q;
    waitCnt_d = waitCnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (wb_src_i == SRC_LOAD) begin
            state_d   = WAIT_MEM;
            waitCnt_d = 8'd0;
          end else begin
            state_d = WRITE;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_rsp_valid_i) begin
          state_d = WRITE;
        end else if (waitCnt_q == WAIT_LAST) begin
          state_d = ERR;
        end else begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end
      WRITE:   state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The mux controls follow the latched instruction for as
  // long as it is in flight and fall back to zero in IDLE.
  always_comb begin
    ready_o         = 1'b0;
    mem_rsp_ready_o = 1'b0;
    retire_o        = 1'b0;
    err_o           = 1'b0;
    reg_we_o        = 1'b0;
    rd_select_o     = 2'b00;
    load_o          = 1'b0;
    reg_waddr_o     = 5'd0;
    load_data_o     = loadData_q;
    if (state_q == IDLE) begin
      ready_o = 1'b1;
    end else begin
      rd_select_o = wbSrc_q;
      load_o      = (wbSrc_q == SRC_LOAD);
      reg_waddr_o = rd_q;
    end
    if (state_q == WAIT_MEM) begin
      mem_rsp_ready_o = 1'b1;
    end
    if (state_q == WRITE) begin
      retire_o = 1'b1;
      reg_we_o = wbEn_q && (rd_q != 5'd0);
    end
    if (state_q == ERR) begin
      err_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_seq_ctrl.sv
module tb_wb_seq_ctrl;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        instrValid = 1'b0;
   logic        wbEn = 1'b0;
   logic [1:0]  wbSrc = 2'b00;
   logic [4:0]  rdAddr = 5'd0;
   logic        memRspValid = 1'b0;
   logic [31:0] memRspData = 32'd0;

   logic        ready_o;
   logic        mem_rsp_ready_o;
   logic [1:0]  rd_select_o;
   logic        load_o;
   logic [31:0] load_data_o;
   logic        reg_we_o;
   logic [4:0]  reg_waddr_o;
   logic        retire_o;
   logic        err_o;

   wb_seq_ctrl #(.TIMEOUT(TO)) dut (
      .clk             (clk),
      .rst             (rst),
      .instr_valid_i   (instrValid),
      .ready_o         (ready_o),
      .wb_en_i         (wbEn),
      .wb_src_i        (wbSrc),
      .rd_addr_i       (rdAddr),
      .mem_rsp_valid_i (memRspValid),
      .mem_rsp_data_i  (memRspData),
      .mem_rsp_ready_o (mem_rsp_ready_o),
      .rd_select_o     (rd_select_o),
      .load_o          (load_o),
      .load_data_o     (load_data_o),
      .reg_we_o        (reg_we_o),
      .reg_waddr_o     (reg_waddr_o),
      .retire_o        (retire_o),
      .err_o           (err_o)
   );

   // Free-running clock and a cycle index used to timestamp events.
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // One expected writeback or error event per issued instruction.
   typedef struct {
      bit          isErr;
      int          evCyc;
      logic [40:0] fields;
   } exp_t;

   exp_t        expQ[$];
   logic [31:0] modelData = 32'd0;
   int          total = 0;
   int          bad = 0;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Monitor: every cycle the write enable must be confined to retire; on a
   // retire or error pulse the oldest expected event is popped and compared.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         checkOutput("we_outside_retire", 64'(reg_we_o & ~retire_o), 64'd0);
         if (retire_o || err_o) begin
            checkOutput("event_expected", 64'(expQ.size() != 0), 64'd1);
            if (expQ.size() != 0) begin
               e = expQ.pop_front();
               checkOutput("err_pulse", 64'(err_o), 64'(e.isErr));
               checkOutput("retire_pulse", 64'(retire_o), 64'(!e.isErr));
               checkOutput("event_cycle", 64'(cyc), 64'(e.evCyc));
               checkOutput("wb_fields", 64'({reg_we_o, reg_waddr_o, rd_select_o, load_o, load_data_o}), 64'(e.fields));
            end
         end
      end
   end

   // Issue one instruction. delay < 0 means no load response; otherwise the
   // response is presented in wait cycle number 'delay' (0-based).
   task automatic applyStimulus(input logic [1:0] src, input logic [4:0] rd, input logic en,
                                input int delay, input bit stray, input logic [31:0] rspData);
      int   waitCnt;
      int   acc;
      exp_t e;
      waitCnt = 0;
      while (!ready_o && waitCnt < 50) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      if (!ready_o) begin
         checkOutput("ready_before_issue", 64'(ready_o), 64'd1);
         return;
      end
      instrValid  = 1'b1;
      wbSrc       = src;
      rdAddr      = rd;
      wbEn        = en;
      memRspValid = stray;
      memRspData  = $urandom;
      @(posedge clk); #1;
      acc         = cyc;
      instrValid  = 1'b0;
      memRspValid = 1'b0;
      wbSrc       = 2'($urandom);
      rdAddr      = 5'($urandom);
      wbEn        = 1'($urandom);
      if (src != 2'b01) begin
         e.isErr  = 1'b0;
         e.evCyc  = acc;
         e.fields = {en && (rd != 5'd0), rd, src, 1'b0, modelData};
      end else if (delay >= 0 && delay < TO) begin
         modelData = rspData;
         e.isErr   = 1'b0;
         e.evCyc   = acc + delay + 1;
         e.fields  = {en && (rd != 5'd0), rd, 2'b01, 1'b1, rspData};
      end else begin
         e.isErr  = 1'b1;
         e.evCyc  = acc + TO;
         e.fields = {1'b0, rd, 2'b01, 1'b1, modelData};
      end
      expQ.push_back(e);
      if (src == 2'b01 && delay >= 0) begin
         repeat (delay) begin
            @(posedge clk); #1;
         end
         memRspValid = 1'b1;
         memRspData  = rspData;
         @(posedge clk); #1;
         memRspValid = 1'b0;
         memRspData  = $urandom;
      end
      waitCnt = 0;
      while (!ready_o && waitCnt < 50) begin
         @(posedge clk); #1;
         waitCnt++;
      end
      checkOutput("ready_return_cycle", 64'(cyc), 64'(e.evCyc + 1));
   endtask

   // Main sequence: reset checks, directed cases, reset corner cases, then
   // randomized traffic.
   initial begin
      instrValid  = 1'b1;
      wbSrc       = 2'b01;
      rdAddr      = 5'd9;
      wbEn        = 1'b1;
      memRspValid = 1'b1;
      memRspData  = 32'h1234_5678;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset_outputs",
                  64'({reg_we_o, retire_o, err_o, mem_rsp_ready_o, load_o, rd_select_o, reg_waddr_o, load_data_o}),
                  64'd0);
      checkOutput("reset_ready", 64'(ready_o), 64'd1);
      instrValid  = 1'b0;
      memRspValid = 1'b0;
      rst         = 1'b0;
      @(posedge clk); #1;
      checkOutput("ready_after_reset", 64'(ready_o), 64'd1);

      applyStimulus(2'b00, 5'd5, 1'b1, 0, 1'b0, 32'd0);
      applyStimulus(2'b01, 5'd7, 1'b1, 3, 1'b0, 32'hDEAD_BEEF);
      applyStimulus(2'b01, 5'd9, 1'b1, -1, 1'b0, 32'd0);
      applyStimulus(2'b01, 5'd10, 1'b1, TO - 1, 1'b0, 32'hCAFE_F00D);
      applyStimulus(2'b01, 5'd11, 1'b1, TO, 1'b0, 32'hBAD0_BAD0);
      applyStimulus(2'b11, 5'd0, 1'b1, 0, 1'b1, 32'd0);
      applyStimulus(2'b01, 5'd12, 1'b0, 1, 1'b0, 32'h0BAD_CAFE);
      applyStimulus(2'b01, 5'd0, 1'b1, 0, 1'b1, 32'h5555_AAAA);
      applyStimulus(2'b10, 5'd31, 1'b1, 0, 1'b0, 32'd0);

      // Reset asserted together with an accept: nothing may be accepted.
      instrValid = 1'b1;
      wbSrc      = 2'b00;
      rdAddr     = 5'd5;
      wbEn       = 1'b1;
      rst        = 1'b1;
      @(posedge clk); #1;
      rst        = 1'b0;
      instrValid = 1'b0;
      modelData  = 32'd0;
      checkOutput("reset_over_accept", 64'({retire_o, reg_we_o, ready_o, load_data_o}), 64'({3'b001, 32'd0}));

      // Reset in the middle of a load wait; later responses are ignored.
      applyStimulus(2'b01, 5'd3, 1'b1, 0, 1'b0, 32'h7777_0001);
      instrValid = 1'b1;
      wbSrc      = 2'b01;
      rdAddr     = 5'd6;
      wbEn       = 1'b1;
      @(posedge clk); #1;
      instrValid = 1'b0;
      @(posedge clk); #1;
      checkOutput("load_waiting", 64'(mem_rsp_ready_o), 64'd1);
      rst         = 1'b1;
      memRspValid = 1'b1;
      memRspData  = 32'hFEED_FACE;
      @(posedge clk); #1;
      modelData = 32'd0;
      checkOutput("reset_mid_load",
                  64'({reg_we_o, retire_o, err_o, mem_rsp_ready_o, load_o, rd_select_o, reg_waddr_o, load_data_o}),
                  64'd0);
      rst = 1'b0;
      checkOutput("ready_after_mid_reset", 64'(ready_o), 64'd1);
      @(posedge clk); #1;
      memRspValid = 1'b0;
      checkOutput("late_rsp_ignored", 64'(load_data_o), 64'(modelData));

      for (int i = 0; i < 150; i++) begin
         applyStimulus(2'($urandom_range(0, 3)), 5'($urandom), 1'($urandom),
                       $urandom_range(0, 5) - 1, ($urandom_range(0, 3) == 0), $urandom);
      end

      repeat (3) @(posedge clk);
      #1;
      checkOutput("queue_drained", 64'(expQ.size()), 64'd0);
      checkOutput("final_load_data", 64'(load_data_o), 64'(modelData));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Guard against a stuck run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
